// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: mode-FSM state codes,
// coin values and display/sales saturation limits.
package vm_pkg;

  typedef enum logic [3:0] {
    S_OFF        = 4'b0000,
    S_INQUIRE    = 4'b0001,
    S_PAYMENT    = 4'b0010,
    S_ADD_AMOUNT = 4'b0011,
    S_SUCCESS    = 4'b0110,
    S_FAILURE    = 4'b0111,
    S_SUC_ADM    = 4'b1011,
    S_RESET      = 4'b1110,
    S_ADM_ADD    = 4'b1111
  } vm_state_e;

  localparam int C_1  = 1;
  localparam int C_5  = 5;
  localparam int C_10 = 10;
  localparam int C_20 = 20;

  localparam int DISP_MAX  = 99;
  localparam int SALES_MAX = 999;

endpackage

// File: rtl/pay_ctrl_if.sv
// Bundle between the mode FSM (master) and pay_ctrl (slave).
// master drives state/item/buttons/coins; slave returns money/credit/status.
interface pay_ctrl_if;
  logic [3:0] state;
  logic [1:0] item_sel;
  logic       switch_plus;
  logic       switch_minus;
  logic       coin_1;
  logic       coin_5;
  logic       coin_10;
  logic       coin_20;
  logic [6:0] sum;
  logic [6:0] money;
  logic       out;
  logic       times_up;
  logic [6:0] change;
  logic [9:0] sales;

  modport master (
    output state, item_sel, switch_plus, switch_minus,
    output coin_1, coin_5, coin_10, coin_20,
    input  sum, money, out, times_up, change, sales
  );

  modport slave (
    input  state, item_sel, switch_plus, switch_minus,
    input  coin_1, coin_5, coin_10, coin_20,
    output sum, money, out, times_up, change, sales
  );
endinterface

// File: rtl/edge_det.sv
// Registered rising-edge detector, W lanes.
// Ports: clk, rst (async, active-high), d_i level in, rise_o = d_i & ~prev.
module edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/pay_ctrl.sv
// Payment/inventory datapath feeding the vending-machine mode FSM.
// Ports: clk, rst_n (async, ACTIVE-HIGH), bus (pay_ctrl_if.slave).
module pay_ctrl
  import vm_pkg::*;
#(
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 5,
  parameter int PRICE2      = 8,
  parameter int PRICE3      = 12,
  parameter int INIT_STOCK  = 5,
  parameter int MAX_STOCK   = 15,
  parameter int MAX_QTY     = 5,
  parameter int TIMEOUT_CYC = 10000000
) (
  input logic       clk,
  input logic       rst_n,
  pay_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [5:0] edg;
  logic e1, e5, e10, e20, e_min, e_pl;

  edge_det #(.W(6)) u_edge (
    .clk    (clk),
    .rst    (rst_n),
    .d_i    ({bus.switch_plus, bus.switch_minus,
              bus.coin_20, bus.coin_10,
              bus.coin_5, bus.coin_1}),
    .rise_o (edg)
  );

  assign e1    = edg[0];
  assign e5    = edg[1];
  assign e10   = edg[2];
  assign e20   = edg[3];
  assign e_min = edg[4];
  assign e_pl  = edg[5];

  logic [3:0]    state_q;
  logic [1:0]    item_q,  item_d;
  logic [3:0]    qty_q,   qty_d;
  logic [6:0]    sum_q,   sum_d;
  logic [6:0]    chg_q,   chg_d;
  logic [9:0]    sales_q, sales_d;
  logic [TW-1:0] tmo_q,   tmo_d;
  logic          tup_q,   tup_d;
  logic [3:0]    stock_q [4];
  logic [3:0]    stock_d [4];

  function automatic logic [6:0] price_of(
    input logic [1:0] i
  );
    case (i)
      2'd0:    price_of = 7'(PRICE0);
      2'd1:    price_of = 7'(PRICE1);
      2'd2:    price_of = 7'(PRICE2);
      default: price_of = 7'(PRICE3);
    endcase
  endfunction

  // Wide product so large prices still saturate cleanly.
  logic [9:0] prod;
  logic [6:0] money_w;
  assign prod    = 10'(price_of(bus.item_sel)) * 10'(qty_q);
  assign money_w = (prod > 10'(DISP_MAX)) ? 7'(DISP_MAX) : prod[6:0];

  logic [7:0] coin_sum;
  assign coin_sum = 8'(sum_q)
                  + (e1  ? 8'(C_1)  : 8'd0)
                  + (e5  ? 8'(C_5)  : 8'd0)
                  + (e10 ? 8'(C_10) : 8'd0)
                  + (e20 ? 8'(C_20) : 8'd0);

  logic [10:0] sales_sum;
  assign sales_sum = 11'(sales_q) + 11'(money_w);

  // Quantity ceiling: the lesser of the per-sale cap and stock on hand.
  logic [3:0] qmax;
  assign qmax = (stock_q[item_q] < 4'(MAX_QTY)) ?
                stock_q[item_q] : 4'(MAX_QTY);

  logic any_coin;
  assign any_coin = e1 | e5 | e10 | e20;

  always_comb begin
    item_d  = item_q;
    qty_d   = qty_q;
    sum_d   = sum_q;
    chg_d   = chg_q;
    sales_d = sales_q;
    stock_d = stock_q;
    tmo_d   = tmo_q;
    tup_d   = 1'b0;
    case (bus.state)
      S_INQUIRE: begin
        item_d = bus.item_sel;
        qty_d  = 4'd1;
        sum_d  = '0;
        chg_d  = '0;
      end
      S_ADD_AMOUNT: begin
        if (e_pl && !e_min && qty_q < qmax)
          qty_d = qty_q + 4'd1;
        else if (e_min && !e_pl && qty_q > 4'd1)
          qty_d = qty_q - 4'd1;
      end
      S_PAYMENT: begin
        sum_d = (coin_sum > 8'(DISP_MAX)) ?
                7'(DISP_MAX) : coin_sum[6:0];
        if (state_q != S_PAYMENT || any_coin)
          tmo_d = '0;
        else if (tmo_q != T_LAST)
          tmo_d = tmo_q + 1'b1;
        // Latches high until the FSM leaves payment.
        tup_d = (tup_q && state_q == S_PAYMENT) ||
                (tmo_d == T_LAST);
      end
      S_SUCCESS: begin
        // Only the first cycle after payment commits.
        if (state_q == S_PAYMENT) begin
          chg_d = (sum_q >= money_w) ? sum_q - money_w : '0;
          stock_d[item_q] = (stock_q[item_q] >= qty_q) ?
                            stock_q[item_q] - qty_q : '0;
          sales_d = (sales_sum > 11'(SALES_MAX)) ?
                    10'(SALES_MAX) : sales_sum[9:0];
        end
      end
      S_FAILURE: begin
        if (state_q == S_PAYMENT)
          chg_d = sum_q;
      end
      S_OFF: begin
        sum_d = '0;
        qty_d = 4'd1;
        chg_d = '0;
        tmo_d = '0;
      end
      S_ADM_ADD: begin
        if (e_pl && stock_q[bus.item_sel] < 4'(MAX_STOCK))
          stock_d[bus.item_sel] = stock_q[bus.item_sel] + 4'd1;
      end
      S_RESET: begin
        if (state_q != S_RESET) begin
          for (int i = 0; i < 4; i++)
            stock_d[i] = 4'(INIT_STOCK);
          sales_d = '0;
        end
      end
      default: tup_d = tup_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_OFF;
      item_q  <= '0;
      qty_q   <= 4'd1;
      sum_q   <= '0;
      chg_q   <= '0;
      sales_q <= '0;
      tmo_q   <= '0;
      tup_q   <= 1'b0;
      for (int i = 0; i < 4; i++)
        stock_q[i] <= 4'(INIT_STOCK);
    end else begin
      state_q <= bus.state;
      item_q  <= item_d;
      qty_q   <= qty_d;
      sum_q   <= sum_d;
      chg_q   <= chg_d;
      sales_q <= sales_d;
      tmo_q   <= tmo_d;
      tup_q   <= tup_d;
      stock_q <= stock_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.money    = money_w;
  assign bus.out      = (stock_q[bus.item_sel] == 4'd0);
  assign bus.times_up = tup_q;
  assign bus.change   = chg_q;
  assign bus.sales    = sales_q;

endmodule
